// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types for the seven-segment display datapath
package display_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} scan_state_t;

   localparam int N_DIGITS = 8;

   typedef logic [3:0] digit_t;
   typedef logic [7:0] anode_t;

   localparam anode_t ANODES_OFF = 8'hFF;

   // Active-low enable pattern for a single digit.
   function automatic anode_t anode_sel(input logic [2:0] idx);
      return ~(anode_t'(1) << idx);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - modulo-MOD prescaler with sync clear, registered terminal-count flag
module tick_gen #(
   parameter int MOD = 16,
   parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o,
   output logic [W-1:0] count_next_o,
   output logic         tc_o
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] count_q, count_d;
   logic         tc_q, tc_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + W'(1);
      end
      // tc is aligned with the count it flags, so it is derived from the next value.
      tc_d = (count_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count_o      = count_q;
   assign count_next_o = count_d;
   assign tc_o         = tc_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-digit scan controller with blanking; SCAN_DIMMING_EN adds brillo PWM
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 100_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [7:0] digit_en,
`ifdef SCAN_DIMMING_EN
   input  logic [3:0] brillo,
`endif
   output logic [2:0] contador,
   output anode_t     anodos,
   output logic       slot_tick
);

   localparam int SLOT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * N_DIGITS);
   localparam int P_W         = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   localparam logic [P_W-1:0] BLANK_P   = P_W'(BLANK_CYCLES);
   localparam logic [P_W-1:0] SLOT_LAST = P_W'(SLOT_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_BLANK = 2'(BLANK);
   localparam logic [1:0] S_DRIVE = 2'(DRIVE);

   if (!(SLOT_CYCLES > BLANK_CYCLES && BLANK_CYCLES >= 1)) begin : g_param_check
      $error("display_scan_ctrl: SLOT_CYCLES > BLANK_CYCLES >= 1 violated");
   end

   logic [1:0]     state_q, state_d;
   logic [2:0]     contador_q, contador_d;
   anode_t         anodos_q, anodos_d;
   logic [P_W-1:0] p, p_next;
   logic           p_clr;
   logic           pwm_on;

   assign p_clr = !enable || (state_q == S_IDLE);

   tick_gen #(.MOD(SLOT_CYCLES), .W(P_W)) u_slot_gen (
      .clk          (clk),
      .reset_n      (reset_n),
      .clr_i        (p_clr),
      .en_i         (1'b1),
      .count_o      (p),
      .count_next_o (p_next),
      .tc_o         (slot_tick)
   );

`ifdef SCAN_DIMMING_EN
   logic [3:0] q, q_next;
   logic       q_tc;
   logic       unused_pwm;

   // PWM phase restarts on every entry into DRIVE so each slot gets the same duty pattern.
   tick_gen #(.MOD(16), .W(4)) u_pwm_gen (
      .clk          (clk),
      .reset_n      (reset_n),
      .clr_i        (state_q != S_DRIVE),
      .en_i         (1'b1),
      .count_o      (q),
      .count_next_o (q_next),
      .tc_o         (q_tc)
   );

   assign unused_pwm = ^{q, q_tc};
   assign pwm_on     = (q_next < brillo);
`else
   assign pwm_on = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      contador_d = contador_q;
      anodos_d   = ANODES_OFF;
      if (!enable) begin
         state_d    = S_IDLE;
         contador_d = 3'd0;
      end else if (state_q == S_IDLE) begin
         state_d    = S_BLANK;
         contador_d = 3'd0;
      end else begin
         // The phase follows the prescaler: a wrap to 0 lands back in BLANK.
         state_d = (p_next < BLANK_P) ? S_BLANK : S_DRIVE;
         if (state_q == S_DRIVE && p == SLOT_LAST) begin
            contador_d = contador_q + 3'd1;
         end
      end
      if (state_d == S_DRIVE && digit_en[contador_d] && pwm_on) begin
         anodos_d = anode_sel(contador_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         contador_q <= 3'd0;
         anodos_q   <= ANODES_OFF;
      end else begin
         state_q    <= state_d;
         contador_q <= contador_d;
         anodos_q   <= anodos_d;
      end
   end

   assign contador = contador_q;
   assign anodos   = anodos_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl against a frame-time model
module tb_display_scan_ctrl;

`ifdef SCAN_DIMMING_EN
   localparam int CLK_HZ = 3200;
   localparam int BLANK  = 8;
`else
   localparam int CLK_HZ = 800;
   localparam int BLANK  = 2;
`endif
   localparam int REF_HZ = 10;
   localparam int SLOT   = CLK_HZ / (REF_HZ * 8);
   localparam int FRAME  = SLOT * 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [7:0] digit_en;
   logic [3:0] brillo;
   logic [2:0] contador;
   logic [7:0] anodos;
   logic       slot_tick;

   int n_cmp = 0;
   int n_bad = 0;

   bit         running = 1'b0;
   int         t = 0;
   int         cur_slot = 0;
   int         cur_p = 0;
   logic [7:0] de_s = 8'h00;
   logic [3:0] br_s = 4'h0;
   int         ticks = 0;
   int         lit = 0;

   display_scan_ctrl #(
      .CLK_FREQ_HZ  (CLK_HZ),
      .REFRESH_HZ   (REF_HZ),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .digit_en  (digit_en),
`ifdef SCAN_DIMMING_EN
      .brillo    (brillo),
`endif
      .contador  (contador),
      .anodos    (anodos),
      .slot_tick (slot_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int lit_per_slot(input logic [3:0] br);
      int n = 0;
      for (int d = 0; d < SLOT - BLANK; d++) begin
`ifdef SCAN_DIMMING_EN
         if ((d % 16) < br) n++;
`else
         n++;
`endif
      end
      return n;
   endfunction

   // One clock: advance the scan-time model from the sampled inputs, then compare outputs.
   task automatic step();
      logic       r = reset_n;
      logic       e = enable;
      logic [7:0] de = digit_en;
      logic [3:0] br = brillo;
      logic [2:0] e_cnt;
      logic [7:0] e_an;
      logic       e_tick;
      logic       on;
      @(posedge clk);
      if (!r || !e) begin
         running = 1'b0;
         t = 0;
      end else if (!running) begin
         running = 1'b1;
         t = 0;
      end else begin
         t++;
      end
      de_s = de;
      br_s = br;
      #1;
      if (!running) begin
         e_cnt = 3'd0; e_an = 8'hFF; e_tick = 1'b0;
         cur_slot = 0; cur_p = 0;
      end else begin
         cur_slot = (t / SLOT) % 8;
         cur_p    = t % SLOT;
         on = (cur_p >= BLANK) && de_s[cur_slot];
`ifdef SCAN_DIMMING_EN
         on = on && (((cur_p - BLANK) % 16) < br_s);
`endif
         e_cnt  = 3'(cur_slot);
         e_an   = on ? ~(8'h01 << cur_slot) : 8'hFF;
         e_tick = (cur_p == SLOT - 1);
      end
      check("contador", 32'(contador), 32'(e_cnt));
      check("anodos", 32'(anodos), 32'(e_an));
      check("slot_tick", 32'(slot_tick), 32'(e_tick));
      check("one_anode_low", 32'($countones(~anodos) <= 1), 32'd1);
      if (slot_tick) ticks++;
      if (anodos != 8'hFF) lit++;
   endtask

   initial begin
      reset_n  = 1'b0;
      enable   = 1'b0;
      digit_en = 8'hFF;
      brillo   = 4'd15;

      repeat (3) step();
      reset_n = 1'b1;
      repeat (6) step();

      enable = 1'b1;
      ticks = 0;
      lit = 0;
      repeat (FRAME) step();
      check("frame_ticks", 32'(ticks), 32'd8);
      check("frame_lit_full", 32'(lit), 32'(8 * lit_per_slot(4'd15)));

      digit_en = 8'b1010_1010;
      repeat (FRAME) step();

      digit_en = 8'hFF;
      brillo   = 4'd4;
      lit = 0;
      repeat (FRAME) step();
      check("frame_lit_br4", 32'(lit), 32'(8 * lit_per_slot(4'd4)));

      brillo = 4'd0;
      lit = 0;
      repeat (FRAME) step();
      check("frame_lit_br0", 32'(lit), 32'(8 * lit_per_slot(4'd0)));

      repeat (600) begin
         enable  = ($urandom_range(0, 39) != 0);
         reset_n = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 7) == 0) digit_en = 8'($urandom);
         if ($urandom_range(0, 15) == 0) brillo = 4'($urandom);
         step();
      end

      reset_n  = 1'b1;
      digit_en = 8'hFF;
      brillo   = 4'd15;
      enable   = 1'b0;
      step();
      enable = 1'b1;
      begin
         int k = 0;
         do begin
            step();
            k++;
         end while (!(running && cur_slot == 5 && cur_p == 6) && k < 4 * FRAME);
         check("reach_digit5_p6", 32'(running && cur_slot == 5 && cur_p == 6), 32'd1);
      end
      enable = 1'b0;
      step();
      check("drop_anodos", 32'(anodos), 32'hFF);
      check("drop_contador", 32'(contador), 32'd0);
      enable = 1'b1;
      step();
      check("restart_blank", 32'(anodos), 32'hFF);
      repeat (BLANK) step();
      check("restart_digit0", 32'(anodos), 32'hFE);

      begin
         int k = 0;
         do begin
            step();
            k++;
         end while (!(running && cur_slot == 3 && cur_p == BLANK + 1) && k < 4 * FRAME);
         check("reach_digit3_drive", 32'(running && cur_slot == 3 && cur_p == BLANK + 1), 32'd1);
      end
      reset_n = 1'b0;
      step();
      check("rst_anodos", 32'(anodos), 32'hFF);
      check("rst_contador", 32'(contador), 32'd0);
      check("rst_tick", 32'(slot_tick), 32'd0);
      reset_n = 1'b1;
      repeat (2 * SLOT) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
